ad_bus_initiator: RTL
=====================

Name: ad_bus_initiator

Overview:
- Initiator (bus master) for the multiplexed address/data register bus.
- Peripheral targets drive their register onto ad[15:0] through a bufif0 bank while read is low. This block is the other end: it turns a valid/ready register request into an address phase, then a write or read data phase.
- It waits for target ack, with a timeout, and returns a single-cycle response.
- It sits between the local control logic and the tri-state pad wrapper. The pad wrapper combines ad_out/ad_oe into the inout ad bus.

Parameters:
- BUSW, 32, width of the ad bus.
- AW, 16, request address width; must be ≤ BUSW.
- DW, 16, data width; must be ≤ BUSW.
- TURN_CYC, 1, bus turnaround cycles before a read data phase; must be ≥ 1.
- TIMEOUT, 255, max data-phase cycles without ack before abort; must be ≥ 1 and < 2^CNTW.
- CNTW, 8, wait/timeout counter width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block idle; request accepted when req_valid && req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  AW  register address.
- req_wdata  input  DW  write data.
- rsp_valid  output  1  single-cycle response strobe.
- rsp_rdata  output  DW  read data; valid with rsp_valid.
- rsp_timeout  output  1  transaction aborted; valid with rsp_valid.
- ad_out  output  BUSW  value driven on ad when ad_oe = 1.
- ad_oe  output  1  initiator drives ad.
- ad_in  input  BUSW  sampled ad bus.
- ale  output  1  address latch enable, high during address phase.
- read  output  1  active-low read strobe; target drives ad[DW-1:0] while low.
- write_n  output  1  active-low write strobe.
- ack  input  1  target completes data phase this cycle.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, ad_out=0, ad_oe=0, ale=0, read=1, write_n=1, counter=0.
- All outputs are flops updated on the same edge as the state register. Outputs shown per state are the values held while in that state.
- IDLE:
  - Outputs: req_ready=1, all strobes inactive, ad_oe=0.
  - On accept: capture write/addr/wdata into holding registers; go ADDR.
- ADDR (exactly 1 cycle):
  - Outputs: ale=1, ad_oe=1, ad_out = zero-extended address. Upper BUSW-AW bits are 0.
  - Next state: WDATA if write, else TURN.
- WDATA:
  - Outputs: ad_oe=1, ad_out = zero-extended wdata, write_n=0.
  - Exit to DONE on ack or timeout.
- TURN (TURN_CYC cycles):
  - Outputs: ad_oe=0, read=1.
  - Counter counts the turnaround; then RDATA.
- RDATA:
  - Outputs: ad_oe=0, read=0.
  - On ack: capture ad_in[DW-1:0] into rsp_rdata; go DONE.
- DONE (1 cycle):
  - Outputs: rsp_valid=1, all strobes inactive, ad_oe=0, req_ready=0.
  - Next state: IDLE.
- Timeout:
  - Counter clears on entry to WDATA/RDATA and increments each cycle in the data phase without ack.
  - If the count reaches TIMEOUT-1 with no ack, go DONE with rsp_timeout=1. On a timed-out read, rsp_rdata=0.
  - Ack in the same cycle as timeout expiry: ack wins, rsp_timeout=0.
- rsp_timeout is cleared in every non-DONE state. rsp_rdata holds its last value outside DONE.
- req_ready=1 only in IDLE. No back-to-back overlap.
  - Minimum write: accept@0, ADDR@1, WDATA+ack@2, rsp_valid@3, next accept@4.
  - Minimum read (TURN_CYC=1): ADDR@1, TURN@2, RDATA+ack@3, rsp_valid@4.
- Ack outside WDATA/RDATA is ignored.
- No bus contention: ad_oe and read=0 are never both asserted. ad_oe falls at least TURN_CYC cycles before read falls.
- Reset mid-transaction aborts immediately: no response is issued and the bus is released (ad_oe=0, strobes inactive).
- Request inputs are don't-care outside the accept cycle.

Test Plan:
- Write, ack on first data cycle: addr 16'h0012, wdata 16'hA5A5 -> ale@1 with ad_out 32'h00000012; write_n=0 and ad_out 32'h0000A5A5 @2; rsp_valid@3 with rsp_timeout=0; req_ready@4.
- Read with 3 wait states: target drives ad_in 32'hFFFF1234, ack on 4th RDATA cycle -> read low 4 cycles, ad_oe=0 throughout TURN/RDATA, rsp_rdata=16'h1234.
- Timeout with TIMEOUT=4, no ack on a read -> exactly 4 RDATA cycles, then rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
- Ack coincident with the last timeout cycle on a write -> rsp_timeout=0.
- Reset asserted in WDATA -> all outputs return to reset values immediately, with no rsp_valid. A subsequent read completes normally.
- Back-to-back: req_valid held high with write then read -> second accept exactly 1 cycle after the first rsp_valid. Check ad_oe && !read never true at any cycle.

Source files
------------

// File: rtl/ad_bus_initiator.sv
// Bus master for the multiplexed address/data register bus: turns a valid/ready
// request into an address phase plus a write or read data phase with ack timeout.
module ad_bus_initiator #(
   parameter int BUSW     = 32,
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int TURN_CYC = 1,
   parameter int TIMEOUT  = 255,
   parameter int CNTW     = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   output logic            rsp_valid,
   output logic [DW-1:0]   rsp_rdata,
   output logic            rsp_timeout,
   output logic [BUSW-1:0] ad_out,
   output logic            ad_oe,
   input  logic [BUSW-1:0] ad_in,
   output logic            ale,
   output logic            read,
   output logic            write_n,
   input  logic            ack
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WDATA = 3'd2,
      TURN  = 3'd3,
      RDATA = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [CNTW-1:0] TO_LAST   = CNTW'(TIMEOUT - 1);
   localparam logic [CNTW-1:0] TURN_LAST = CNTW'(TURN_CYC - 1);

   state_t          state_r, state_s;
   logic [CNTW-1:0] cnt_r, cnt_s;
   logic            write_r;
   logic [DW-1:0]   wdata_r;
   logic            accept_s;
   logic            data_phase_s;

   logic            req_ready_s, rsp_valid_s, rsp_timeout_s;
   logic [DW-1:0]   rsp_rdata_s;
   logic [BUSW-1:0] ad_out_s;
   logic            ad_oe_s, ale_s, read_s, write_n_s;

   assign accept_s     = req_valid && req_ready && (state_r == IDLE);
   assign data_phase_s = (state_r == WDATA) || (state_r == RDATA);

   // State, counter and request holding registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         write_r <= 1'b0;
         wdata_r <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         if (accept_s) begin
            write_r <= req_write;
            wdata_r <= req_wdata;
         end else begin
            write_r <= write_r;
            wdata_r <= wdata_r;
         end
      end
   end

   // Next-state and wait/turnaround counter.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = accept_s ? ADDR : IDLE;
         ADDR:    state_s = write_r ? WDATA : TURN;
         WDATA:   state_s = (ack || cnt_r == TO_LAST) ? DONE : WDATA;
         TURN:    state_s = (cnt_r == TURN_LAST) ? RDATA : TURN;
         RDATA:   state_s = (ack || cnt_r == TO_LAST) ? DONE : RDATA;
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
      // Counter restarts on every state entry, so it times both TURN and data phases.
      if (state_s != state_r) begin
         cnt_s = '0;
      end else if (data_phase_s || state_r == TURN) begin
         cnt_s = cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
         cnt_s = '0;
      end
   end

   // Output values for the state being entered, registered on the same edge.
   always_comb begin
      req_ready_s   = 1'b0;
      rsp_valid_s   = 1'b0;
      rsp_timeout_s = 1'b0;
      rsp_rdata_s   = rsp_rdata;
      ad_out_s      = '0;
      ad_oe_s       = 1'b0;
      ale_s         = 1'b0;
      read_s        = 1'b1;
      write_n_s     = 1'b1;
      case (state_s)
         IDLE:  req_ready_s = 1'b1;
         ADDR: begin
            ale_s    = 1'b1;
            ad_oe_s  = 1'b1;
            ad_out_s = BUSW'(req_addr);
         end
         WDATA: begin
            ad_oe_s   = 1'b1;
            write_n_s = 1'b0;
            ad_out_s  = BUSW'(wdata_r);
         end
         TURN:  read_s = 1'b1;
         RDATA: read_s = 1'b0;
         DONE: begin
            rsp_valid_s   = 1'b1;
            rsp_timeout_s = data_phase_s && !ack;
            if (state_r == RDATA) begin
               rsp_rdata_s = ack ? ad_in[DW-1:0] : '0;
            end else begin
               rsp_rdata_s = rsp_rdata;
            end
         end
         default: req_ready_s = 1'b0;
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_timeout <= 1'b0;
         ad_out      <= '0;
         ad_oe       <= 1'b0;
         ale         <= 1'b0;
         read        <= 1'b1;
         write_n     <= 1'b1;
      end else begin
         req_ready   <= req_ready_s;
         rsp_valid   <= rsp_valid_s;
         rsp_rdata   <= rsp_rdata_s;
         rsp_timeout <= rsp_timeout_s;
         ad_out      <= ad_out_s;
         ad_oe       <= ad_oe_s;
         ale         <= ale_s;
         read        <= read_s;
         write_n     <= write_n_s;
      end
   end

endmodule
